// File: rtl/irq_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: register map, FSM states,
// spurious vector offset and a lowest-set-bit helper.
package irq_seq_pkg;

    localparam logic [2:0] REG_MASK    = 3'd0;
    localparam logic [2:0] REG_PENDING = 3'd1;
    localparam logic [2:0] REG_INSVC   = 3'd2;
    localparam logic [2:0] REG_EOI     = 3'd3;
    localparam logic [2:0] REG_VBASE   = 3'd4;

    localparam logic [7:0] SPUR_OFFSET = 8'd16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Index 0 is the highest priority, so the lowest set bit wins.
    function automatic pick_t lowest_set(input logic [7:0] v);
        pick_t p;
        p.found = 1'b0;
        p.idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                p.found = 1'b1;
                p.idx   = 3'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Bus bundle between peripherals/CPU (master side) and the interrupt
// sequencer (slave side).
interface irq_sequencer_if #(
    parameter int NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0] irq_n;
    logic               ack_n;
    logic               int_n;
    logic [7:0]         vec;
    logic               vec_valid;
    logic [2:0]         reg_addr;
    logic               reg_wr;
    logic               reg_rd;
    logic [7:0]         reg_wdata;
    logic [7:0]         reg_rdata;

    modport master (
        output irq_n, ack_n, reg_addr, reg_wr, reg_rd, reg_wdata,
        input  int_n, vec, vec_valid, reg_rdata
    );

    modport slave (
        input  irq_n, ack_n, reg_addr, reg_wr, reg_rd, reg_wdata,
        output int_n, vec, vec_valid, reg_rdata
    );
endinterface

// File: rtl/irq_sequencer_edge_sync.sv
// Per-bit 2-flop synchronizer followed by a falling-edge detector. All flops
// reset high so leaving reset never looks like a request.
module irq_edge_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_async_n,
    output logic [W-1:0] o_fall
);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            logic r_meta;
            logic r_sync;
            logic r_prev;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_meta <= 1'b1;
                    r_sync <= 1'b1;
                    r_prev <= 1'b1;
                end else begin
                    r_meta <= i_async_n[gi];
                    r_sync <= r_meta;
                    r_prev <= r_sync;
                end
            end

            assign o_fall[gi] = r_prev & ~r_sync;
        end
    endgenerate

endmodule

// File: rtl/irq_sequencer.sv
// Priority interrupt sequencer: pending/in-service tracking, int_n/acknowledge
// FSM and register window. IRQ_SEQ_NESTING_EN enables priority nesting.
module irq_sequencer
    import irq_seq_pkg::*;
#(
    parameter int         NUM_IRQ   = 8,
    parameter logic [7:0] VBASE_RST = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    irq_sequencer_if.slave bus
);

    localparam logic [7:0] VALID_MASK = 8'((9'd1 << NUM_IRQ) - 9'd1);

    logic [NUM_IRQ-1:0] w_fall;
    logic [7:0]         w_fall8;

    state_t     r_state, w_state_next;
    logic       r_int_n, w_int_n_next;
    logic [7:0] r_vec, w_vec_next;
    logic       r_vec_valid, w_vec_valid_next;
    logic       w_take;

    logic [7:0] r_pending, w_pending_next;
    logic [7:0] r_insvc, w_insvc_next;
    logic [7:0] r_mask;
    logic [7:0] r_vbase;
    logic [7:0] r_rdata, w_rdata_next;

    pick_t      w_ins_low;
    pick_t      w_win;
    logic [7:0] w_elig;
    logic [7:0] w_cand;
    logic [7:0] w_win_bit;
    logic [7:0] w_eoi_bit;

    irq_edge_sync #(.W(NUM_IRQ)) u_edge_sync (
        .clk       (clk),
        .rst       (rst),
        .i_async_n (bus.irq_n),
        .o_fall    (w_fall)
    );

    assign w_fall8   = 8'(w_fall);
    assign w_ins_low = lowest_set(r_insvc);
    assign w_elig    = r_pending & ~r_mask;

`ifdef IRQ_SEQ_NESTING_EN
    // Only sources strictly above the highest-priority in-service one compete.
    assign w_cand = w_ins_low.found ? (w_elig & ((8'd1 << w_ins_low.idx) - 8'd1)) : w_elig;
`else
    assign w_cand = w_ins_low.found ? 8'h00 : w_elig;
`endif

    assign w_win     = lowest_set(w_cand);
    assign w_win_bit = 8'd1 << w_win.idx;
    assign w_eoi_bit = 8'd1 << w_ins_low.idx;

    always_comb begin
        w_state_next     = r_state;
        w_int_n_next     = r_int_n;
        w_vec_next       = r_vec;
        w_vec_valid_next = r_vec_valid;
        w_take           = 1'b0;
        case (r_state)
            IDLE: begin
                w_int_n_next     = 1'b1;
                w_vec_valid_next = 1'b0;
                if (w_win.found) begin
                    w_state_next = ASSERT;
                    w_int_n_next = 1'b0;
                end
            end
            ASSERT: begin
                w_int_n_next = 1'b0;
                if (!bus.ack_n) begin
                    w_state_next     = ACK;
                    w_int_n_next     = 1'b1;
                    w_vec_valid_next = 1'b1;
                    // Winner is re-evaluated here; it may have vanished since int_n fell.
                    if (w_win.found) begin
                        w_take     = 1'b1;
                        w_vec_next = r_vbase + {4'd0, w_win.idx, 1'b0};
                    end else begin
                        w_vec_next = r_vbase + SPUR_OFFSET;
                    end
                end
            end
            ACK: begin
                w_int_n_next     = 1'b1;
                w_vec_valid_next = 1'b1;
                if (bus.ack_n) begin
                    w_state_next     = IDLE;
                    w_vec_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_int_n     <= 1'b1;
            r_vec       <= 8'h00;
            r_vec_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_int_n     <= w_int_n_next;
            r_vec       <= w_vec_next;
            r_vec_valid <= w_vec_valid_next;
        end
    end

    // Ordering encodes precedence: w1c < edge set < acknowledge clear.
    always_comb begin
        w_pending_next = r_pending;
        if (bus.reg_wr && (bus.reg_addr == REG_PENDING)) begin
            w_pending_next = w_pending_next & ~bus.reg_wdata;
        end
        w_pending_next = w_pending_next | w_fall8;
        if (w_take) begin
            w_pending_next = w_pending_next & ~w_win_bit;
        end
        w_pending_next = w_pending_next & VALID_MASK;

        w_insvc_next = r_insvc;
        if (bus.reg_wr && (bus.reg_addr == REG_EOI) && w_ins_low.found) begin
            w_insvc_next = w_insvc_next & ~w_eoi_bit;
        end
        if (w_take) begin
            w_insvc_next = w_insvc_next | w_win_bit;
        end
    end

    always_comb begin
        w_rdata_next = r_rdata;
        if (bus.reg_rd) begin
            case (bus.reg_addr)
                REG_MASK:    w_rdata_next = r_mask;
                REG_PENDING: w_rdata_next = r_pending;
                REG_INSVC:   w_rdata_next = r_insvc;
                REG_VBASE:   w_rdata_next = r_vbase;
                default:     w_rdata_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 8'h00;
            r_insvc   <= 8'h00;
            r_mask    <= VALID_MASK;
            r_vbase   <= VBASE_RST;
            r_rdata   <= 8'h00;
        end else begin
            r_pending <= w_pending_next;
            r_insvc   <= w_insvc_next;
            r_rdata   <= w_rdata_next;
            if (bus.reg_wr && (bus.reg_addr == REG_MASK)) begin
                r_mask <= bus.reg_wdata & VALID_MASK;
            end
            if (bus.reg_wr && (bus.reg_addr == REG_VBASE)) begin
                r_vbase <= bus.reg_wdata;
            end
        end
    end

    assign bus.int_n     = r_int_n;
    assign bus.vec       = r_vec;
    assign bus.vec_valid = r_vec_valid;
    assign bus.reg_rdata = r_rdata;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed scenarios followed by randomized traffic checked against a
// rule-level model of pending/in-service state and the int_n request.
`timescale 1ns/1ps
module tb_irq_sequencer;
    import irq_seq_pkg::*;

    localparam int NUM_IRQ = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_sequencer_if #(.NUM_IRQ(NUM_IRQ)) bus ();

    irq_sequencer #(.NUM_IRQ(NUM_IRQ), .VBASE_RST(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state
    logic [7:0] m_pend;
    logic [7:0] m_insvc;
    logic [7:0] m_mask;
    logic [7:0] m_vbase;
    logic       m_asserted;
    logic [7:0] m_lvl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_wr    = 1'b1;
        tick();
        bus.reg_wr    = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
        bus.reg_addr = a;
        bus.reg_rd   = 1'b1;
        tick();
        bus.reg_rd   = 1'b0;
        d = bus.reg_rdata;
    endtask

    task automatic ack_seq(output logic [7:0] v, output logic vv);
        bus.ack_n = 1'b0;
        tick();
        v  = bus.vec;
        vv = bus.vec_valid;
        bus.ack_n = 1'b1;
        tick();
    endtask

    task automatic pulse_irq(input int b);
        bus.irq_n[b] = 1'b0;
        ticks(2);
        bus.irq_n[b] = 1'b1;
        ticks(3);
    endtask

    // Winner by rule: lowest eligible index with no in-service bit at or below it.
    function automatic int m_winner();
        for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && !m_mask[i]) begin
`ifdef IRQ_SEQ_NESTING_EN
                if ((int'(m_insvc) % (1 << (i + 1))) == 0) return i;
`else
                if (m_insvc == 8'h00) return i;
`endif
            end
        end
        return -1;
    endfunction

    task automatic m_write(input logic [2:0] a, input logic [7:0] d);
        reg_write(a, d);
        case (a)
            REG_MASK:    m_mask = d;
            REG_PENDING: m_pend = m_pend & ~d;
            REG_EOI: begin
                for (int i = 0; i < 8; i++) begin
                    if (m_insvc[i]) begin
                        m_insvc[i] = 1'b0;
                        break;
                    end
                end
            end
            REG_VBASE:   m_vbase = d;
            default: ;
        endcase
        ticks(2);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] v;
        logic       vv;
        int         act;
        int         b;
        int         w;
        logic [7:0] d;
        logic [7:0] exp_vec;

        bus.irq_n     = '1;
        bus.ack_n     = 1'b1;
        bus.reg_addr  = 3'd0;
        bus.reg_wr    = 1'b0;
        bus.reg_rd    = 1'b0;
        bus.reg_wdata = 8'h00;
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_int_n", bus.int_n, 1);
        check("rst_vec", bus.vec, 0);
        check("rst_vec_valid", bus.vec_valid, 0);
        check("rst_rdata", bus.reg_rdata, 0);
        reg_read(REG_MASK, rd);    check("rst_mask", rd, 8'hFF);
        reg_read(REG_PENDING, rd); check("rst_pending", rd, 8'h00);
        reg_read(REG_INSVC, rd);   check("rst_insvc", rd, 8'h00);
        reg_read(REG_VBASE, rd);   check("rst_vbase", rd, 8'h00);
        reg_read(3'd6, rd);        check("rsvd_read", rd, 8'h00);

        // Basic request on bit 0, latency and acknowledge
        reg_write(REG_MASK, 8'hFE);
        reg_write(REG_VBASE, 8'h40);
        bus.irq_n[0] = 1'b0;
        ticks(2);
        bus.irq_n[0] = 1'b1;
        tick();
        check("t1_int_n_3cyc", bus.int_n, 1);
        tick();
        check("t1_int_n_4cyc", bus.int_n, 0);
        bus.ack_n = 1'b0;
        tick();
        check("t1_vec_valid", bus.vec_valid, 1);
        check("t1_vec", bus.vec, 8'h40);
        check("t1_int_n_ack", bus.int_n, 1);
        reg_read(REG_INSVC, rd);   check("t1_insvc", rd, 8'h01);
        reg_read(REG_PENDING, rd); check("t1_pending", rd, 8'h00);
        check("t1_vec_hold", bus.vec, 8'h40);
        bus.ack_n = 1'b1;
        tick();
        check("t1_vec_valid_fall", bus.vec_valid, 0);
        reg_write(REG_EOI, 8'h00);
        ticks(2);

        // Nesting: bit 3 in service, bit 1 arrives
        reg_write(REG_MASK, 8'h00);
        pulse_irq(3);
        check("t2_int_n_b3", bus.int_n, 0);
        ack_seq(v, vv);
        check("t2_vec_b3", v, 8'h46);
        pulse_irq(1);
`ifdef IRQ_SEQ_NESTING_EN
        check("t2_int_n_nested", bus.int_n, 0);
        ack_seq(v, vv);
        check("t2_vec_b1", v, 8'h42);
        reg_read(REG_INSVC, rd);   check("t2_insvc_0a", rd, 8'h0A);
        reg_write(REG_EOI, 8'h00);
        reg_read(REG_INSVC, rd);   check("t2_eoi_first", rd, 8'h08);
        reg_write(REG_EOI, 8'h00);
        reg_read(REG_INSVC, rd);   check("t2_eoi_second", rd, 8'h00);
`else
        check("t2_int_n_blocked", bus.int_n, 1);
        reg_read(REG_INSVC, rd);   check("t2_insvc_08", rd, 8'h08);
        reg_write(REG_EOI, 8'h00);
        ticks(2);
        check("t2_int_n_after_eoi", bus.int_n, 0);
        ack_seq(v, vv);
        check("t2_vec_b1", v, 8'h42);
        reg_read(REG_INSVC, rd);   check("t2_insvc_02", rd, 8'h02);
        reg_write(REG_EOI, 8'h00);
        reg_read(REG_INSVC, rd);   check("t2_insvc_clear", rd, 8'h00);
`endif
        ticks(2);

        // Simultaneous requests on bits 5 and 2
        bus.irq_n[5] = 1'b0;
        bus.irq_n[2] = 1'b0;
        ticks(2);
        bus.irq_n[5] = 1'b1;
        bus.irq_n[2] = 1'b1;
        ticks(3);
        ack_seq(v, vv);
        check("t3_vec_b2", v, 8'h44);
        ticks(2);
        check("t3_int_n_wait", bus.int_n, 1);
        reg_write(REG_EOI, 8'h00);
        ticks(2);
        check("t3_int_n_b5", bus.int_n, 0);
        ack_seq(v, vv);
        check("t3_vec_b5", v, 8'h4A);
        reg_write(REG_EOI, 8'h00);
        ticks(2);

        // Spurious acknowledge after masking
        pulse_irq(4);
        check("t4_int_n", bus.int_n, 0);
        reg_write(REG_MASK, 8'hFF);
        ticks(2);
        check("t4_int_n_held", bus.int_n, 0);
        ack_seq(v, vv);
        check("t4_vec_spur", v, 8'h50);
        check("t4_vv_spur", vv, 1);
        reg_read(REG_INSVC, rd);   check("t4_insvc", rd, 8'h00);
        reg_read(REG_PENDING, rd); check("t4_pending", rd, 8'h10);
        reg_write(REG_PENDING, 8'h10);
        reg_write(REG_MASK, 8'h00);
        ticks(2);

        // Vector wrap
        reg_write(REG_VBASE, 8'hF8);
        pulse_irq(7);
        ack_seq(v, vv);
        check("t5_vec_wrap", v, 8'h06);
        reg_write(REG_EOI, 8'h00);
        ticks(2);

        // Edge set beats write-1-clear, then reset mid-acknowledge
        reg_write(REG_MASK, 8'hFF);
        pulse_irq(6);
        reg_read(REG_PENDING, rd); check("t6_pend_before", rd, 8'h40);
        bus.irq_n[6] = 1'b0;
        ticks(2);
        reg_write(REG_PENDING, 8'h40);
        bus.irq_n[6] = 1'b1;
        reg_read(REG_PENDING, rd); check("t6_set_wins", rd, 8'h40);
        ticks(3);
        reg_write(REG_MASK, 8'h00);
        tick();
        check("t6_int_n", bus.int_n, 0);
        bus.ack_n = 1'b0;
        tick();
        check("t6_vv", bus.vec_valid, 1);
        check("t6_vec", bus.vec, 8'h04);
        rst = 1'b1;
        tick();
        check("t6_rst_int_n", bus.int_n, 1);
        check("t6_rst_vv", bus.vec_valid, 0);
        check("t6_rst_vec", bus.vec, 0);
        check("t6_rst_rdata", bus.reg_rdata, 0);
        rst = 1'b0;
        bus.ack_n = 1'b1;
        tick();
        reg_read(REG_MASK, rd);    check("t6_rst_mask", rd, 8'hFF);
        reg_read(REG_PENDING, rd); check("t6_rst_pending", rd, 8'h00);
        reg_read(REG_INSVC, rd);   check("t6_rst_insvc", rd, 8'h00);
        reg_read(REG_VBASE, rd);   check("t6_rst_vbase", rd, 8'h00);

        // Randomized traffic against the model
        m_pend     = 8'h00;
        m_insvc    = 8'h00;
        m_mask     = 8'hFF;
        m_vbase    = 8'h00;
        m_asserted = 1'b0;
        m_lvl      = 8'hFF;
        for (int it = 0; it < 250; it++) begin
            act = int'($urandom_range(0, 10));
            case (act)
                0, 1, 2: begin
                    b = int'($urandom_range(0, 7));
                    if (m_lvl[b]) begin
                        bus.irq_n[b] = 1'b0;
                        m_lvl[b] = 1'b0;
                        ticks(6);
                        m_pend[b] = 1'b1;
                    end else begin
                        bus.irq_n[b] = 1'b1;
                        m_lvl[b] = 1'b1;
                        ticks(3);
                    end
                end
                3: begin
                    d = 8'($urandom & $urandom);
                    m_write(REG_MASK, d);
                end
                4: begin
                    d = 8'($urandom & $urandom);
                    m_write(REG_PENDING, d);
                end
                5, 6: m_write(REG_EOI, 8'($urandom));
                7: m_write(REG_VBASE, 8'($urandom));
                8, 9: begin
                    bus.ack_n = 1'b0;
                    tick();
                    if (m_asserted) begin
                        w = m_winner();
                        if (w >= 0) begin
                            exp_vec = 8'((int'(m_vbase) + 2 * w) % 256);
                            m_insvc[w] = 1'b1;
                            m_pend[w] = 1'b0;
                        end else begin
                            exp_vec = 8'((int'(m_vbase) + 16) % 256);
                        end
                        check("rnd_vv", bus.vec_valid, 1);
                        check("rnd_vec", bus.vec, exp_vec);
                        tick();
                        check("rnd_vec_hold", bus.vec, exp_vec);
                        check("rnd_int_n_ack", bus.int_n, 1);
                        bus.ack_n = 1'b1;
                        tick();
                        check("rnd_vv_fall", bus.vec_valid, 0);
                        m_asserted = 1'b0;
                        ticks(2);
                    end else begin
                        check("rnd_idle_ack", bus.vec_valid, 0);
                        bus.ack_n = 1'b1;
                        tick();
                    end
                end
                default: begin
                    reg_read(REG_PENDING, rd); check("rnd_pending", rd, m_pend);
                    reg_read(REG_INSVC, rd);   check("rnd_insvc", rd, m_insvc);
                    reg_read(REG_MASK, rd);    check("rnd_mask", rd, m_mask);
                    reg_read(REG_VBASE, rd);   check("rnd_vbase", rd, m_vbase);
                end
            endcase
            if (m_winner() >= 0) m_asserted = 1'b1;
            check("rnd_int_n", bus.int_n, m_asserted ? 0 : 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
